calc_seg_display: RTL and testbench
===================================

// Module: calc_seg_display
//
// PURPOSE
// - Downstream display stage for the calculator: takes the 8-bit unsigned result from calc (outC)
//   and shows it in decimal (0..255) on a 3-digit multiplexed, common-anode 7-segment display.
// - Converts binary to BCD sequentially (double-dabble), latches the digits and time-multiplexes the anodes.
// - Optionally blanks leading zeros. Sits between calc and the board pins.
//
// PARAMETERS
// - DATA_W     8      width of din; fixed 3 digits, so DATA_W <= 9 is supported
// - SCAN_DIV   50000  clk cycles each digit stays lit; minimum 2
// - BLANK_LZ   1      1 = blank leading zeros (ones digit is never blanked)
//
// PORTS
// - clk   in   1       single system clock; all state changes on its rising edge
// - rst   in   1       synchronous, active-high reset
// - din   in   DATA_W  binary value to display (driven by calc.outC)
// - busy  out  1       high while a conversion is in progress
// - an    out  3       anode enables, active-low; an[0] = ones, an[1] = tens, an[2] = hundreds
// - seg   out  7       segments {g,f,e,d,c,b,a}, active-low
// - dp    out  1       decimal point, active-low; held at 1 (off)
//
// BEHAVIOUR
// - Reset (rst=1 at an edge)
//   - Outputs: an=3'b111, seg=7'h7F, dp=1, busy=0.
//   - State: FSM=IDLE, shown_val=0, digit regs=0, scan index=0, prescaler=0.
//   - Takes effect on the next edge regardless of FSM state. A conversion in flight is discarded and the digit regs are not updated.
// - FSM states: IDLE -> CONV -> LOAD -> IDLE.
//   - IDLE: if din != shown_val, latch din into the shift register, clear the bit counter, set busy=1 and go to CONV.
//     Otherwise stay in IDLE.
//   - CONV: one double-dabble step per cycle: add 3 to every BCD nibble >= 5, then shift left by 1.
//     After DATA_W steps, go to LOAD.
//   - LOAD: copy the BCD nibbles into the digit regs, set shown_val <= latched value, busy=0, go to IDLE.
// - Latency: if din is sampled in IDLE at edge N, the digit regs update and busy falls at edge N+DATA_W+1 (N+9 by default).
// - din changes during CONV/LOAD are ignored. Back in IDLE, the mismatch with shown_val is detected and a new conversion starts. No value is lost permanently.
// - Scan
//   - The prescaler counts 0..SCAN_DIV-1. At terminal count the scan index advances 0->1->2->0 (wraps).
//   - an and seg are registered: they reflect the new index and the current digit regs one cycle after the index changes.
//   - Exactly one anode is low per cycle, unless that digit is blanked, in which case an=3'b111 for that slot.
// - Blanking (BLANK_LZ=1)
//   - Hundreds digit is blanked when it is 0.
//   - Tens digit is blanked when hundreds=0 and tens=0.
//   - A blanked slot still consumes its scan time, so brightness stays uniform.
// - Segment codes: 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010 6=0000010 7=1111000 8=0000000 9=0010000.
//   A nibble > 9 (cannot occur) drives 7'h7F.
//
// STRUCTURE
// - Shared package calc_pkg holds:
//   - the segment code table and SEG_OFF = 7'h7F;
//   - FSM state encodings (IDLE/CONV/LOAD);
//   - digit index constants DIG_ONES/DIG_TENS/DIG_HUND.
// - One sub-module, calc_bin2bcd: the sequential double-dabble FSM
//   - ports: clk, rst, start, bin, busy, done, bcd[11:0].
// - The top level contains the compare/start logic, the scan prescaler, blanking, and the segment decode/output registers.
//
// TESTING
// - Reset: hold rst=1 for 2 cycles, din=0 -> an=111, seg=7F, busy=0. After release, only an=110 is ever low and seg=1000000 ("0").
// - din=255 (SCAN_DIV=4) -> busy high for 9 cycles. Then ones: an=110, seg=0010010; tens: an=101, seg=0010010; hundreds: an=011, seg=0100100.
// - din=255 then din=7 -> after conversion, an[1] and an[2] are never low. In the ones slot, seg=1111000.
// - din=100, then din=42 three cycles into CONV -> display shows 1,0,0 first; busy re-asserts the cycle after LOAD and the display becomes 4,2.
// - Mid-conversion reset: din=200, assert rst at the 4th CONV cycle -> next cycle has reset outputs and busy=0. The display is "0" until din is re-converted.
// - Scan wrap (SCAN_DIV=4, din=128) -> an sequence 110,101,011,110 with each value held 4 cycles. Index wraps cleanly with no cycle at an=111.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator display path: segment codes,
// converter FSM states and digit slot indices.
package calc_pkg;

    // Converter FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        LOAD = 2'd2
    } convState_t;

    // Number of decimal digits on the display
    localparam int NUM_DIGITS = 3;

    // Scan slot indices (also the anode bit positions)
    localparam logic [1:0] DIG_ONES = 2'd0;
    localparam logic [1:0] DIG_TENS = 2'd1;
    localparam logic [1:0] DIG_HUND = 2'd2;

    // Active-low segment patterns {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [6:0] SEG_0   = 7'b1000000;
    localparam logic [6:0] SEG_1   = 7'b1111001;
    localparam logic [6:0] SEG_2   = 7'b0100100;
    localparam logic [6:0] SEG_3   = 7'b0110000;
    localparam logic [6:0] SEG_4   = 7'b0011001;
    localparam logic [6:0] SEG_5   = 7'b0010010;
    localparam logic [6:0] SEG_6   = 7'b0000010;
    localparam logic [6:0] SEG_7   = 7'b1111000;
    localparam logic [6:0] SEG_8   = 7'b0000000;
    localparam logic [6:0] SEG_9   = 7'b0010000;

    // BCD nibble to segment pattern; non-decimal nibbles show nothing
    function automatic logic [6:0] segEncode(input logic [3:0] nibble);
        logic [6:0] code;
        case (nibble)
            4'd0:    code = SEG_0;
            4'd1:    code = SEG_1;
            4'd2:    code = SEG_2;
            4'd3:    code = SEG_3;
            4'd4:    code = SEG_4;
            4'd5:    code = SEG_5;
            4'd6:    code = SEG_6;
            4'd7:    code = SEG_7;
            4'd8:    code = SEG_8;
            4'd9:    code = SEG_9;
            default: code = SEG_OFF;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/calc_bin2bcd.sv
// Sequential double-dabble binary-to-BCD converter.
// One shift step per cycle; done is high for the single LOAD cycle while
// bcd holds the finished three-digit result.
module calc_bin2bcd
    import calc_pkg::*;
#(
    parameter int DATA_W = 8
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] bin,
    output logic              busy,
    output logic              done,
    output logic [11:0]       bcd
);

    localparam int SR_W  = DATA_W + 12;
    localparam int CNT_W = $clog2(DATA_W + 1);

    convState_t       stateReg, stateNext;
    logic [CNT_W-1:0] cntReg, cntNext;
    logic [SR_W-1:0]  shiftReg, shiftNext;
    logic             busyReg, busyNext;

    logic [11:0]      adjBcd;
    logic [SR_W-1:0]  adjusted;
    logic [SR_W-1:0]  stepVal;

    // Add-3 correction on every BCD nibble that would overflow when doubled
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_adj
            logic [3:0] nib;
            assign nib = shiftReg[DATA_W + gi*4 +: 4];
            assign adjBcd[gi*4 +: 4] = (nib >= 4'd5) ? (nib + 4'd3) : nib;
        end
    endgenerate

    assign adjusted = {adjBcd, shiftReg[DATA_W-1:0]};
    assign stepVal  = adjusted << 1;

    // Next-state logic: latch on start, DATA_W shift steps, one LOAD cycle
    always_comb begin
        stateNext = stateReg;
        cntNext   = cntReg;
        shiftNext = shiftReg;
        busyNext  = busyReg;
        case (stateReg)
            IDLE: begin
                if (start) begin
                    shiftNext = {12'd0, bin};
                    cntNext   = '0;
                    busyNext  = 1'b1;
                    stateNext = CONV;
                end
            end
            CONV: begin
                shiftNext = stepVal;
                if (cntReg == CNT_W'(DATA_W - 1)) begin
                    stateNext = LOAD;
                end else begin
                    cntNext = cntReg + CNT_W'(1);
                end
            end
            LOAD: begin
                busyNext  = 1'b0;
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // State register; reset discards any conversion in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            stateReg <= IDLE;
            cntReg   <= '0;
            shiftReg <= '0;
            busyReg  <= 1'b0;
        end else begin
            stateReg <= stateNext;
            cntReg   <= cntNext;
            shiftReg <= shiftNext;
            busyReg  <= busyNext;
        end
    end

    assign busy = busyReg;
    assign done = (stateReg == LOAD);
    assign bcd  = shiftReg[DATA_W +: 12];

endmodule

// File: rtl/calc_seg_display.sv
// Decimal display stage: converts the calculator result to BCD whenever it
// changes, and scans three common-anode digits with optional leading-zero
// blanking. Anode and segment outputs are registered.
module calc_seg_display
    import calc_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int SCAN_DIV = 50000,
    parameter int BLANK_LZ = 1
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    output logic              busy,
    output logic [2:0]        an,
    output logic [6:0]        seg,
    output logic              dp
);

    localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [DATA_W-1:0] shownValReg;
    logic [DATA_W-1:0] pendingValReg;
    logic [11:0]       digitsReg;
    logic [PRE_W-1:0]  preReg;
    logic [1:0]        idxReg;
    logic [2:0]        anReg, anNext;
    logic [6:0]        segReg, segNext;

    logic              convBusy;
    logic              convDone;
    logic [11:0]       convBcd;
    logic              start;

    logic [NUM_DIGITS-1:0] slotBlank;
    logic [6:0]            slotSeg [NUM_DIGITS];

    // A new conversion is requested only while the converter is idle
    assign start = !convBusy && (din != shownValReg);

    calc_bin2bcd #(
        .DATA_W (DATA_W)
    ) u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (din),
        .busy  (convBusy),
        .done  (convDone),
        .bcd   (convBcd)
    );

    // Capture the value being converted; publish digits when it completes
    always_ff @(posedge clk) begin
        if (rst) begin
            pendingValReg <= '0;
            shownValReg   <= '0;
            digitsReg     <= '0;
        end else begin
            if (start) begin
                pendingValReg <= din;
            end
            if (convDone) begin
                digitsReg   <= convBcd;
                shownValReg <= pendingValReg;
            end
        end
    end

    // Scan prescaler and digit slot index (ones -> tens -> hundreds -> ones)
    always_ff @(posedge clk) begin
        if (rst) begin
            preReg <= '0;
            idxReg <= DIG_ONES;
        end else if (preReg == PRE_W'(SCAN_DIV - 1)) begin
            preReg <= '0;
            idxReg <= (idxReg == DIG_HUND) ? DIG_ONES : (idxReg + 2'd1);
        end else begin
            preReg <= preReg + PRE_W'(1);
        end
    end

    // Per-slot segment code and blanking: a slot blanks when it and every
    // higher digit are zero; the ones slot always shows
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_slot
            assign slotSeg[gi] = segEncode(digitsReg[gi*4 +: 4]);
            if (gi == 0 || BLANK_LZ == 0) begin : g_keep
                assign slotBlank[gi] = 1'b0;
            end else begin : g_lz
                assign slotBlank[gi] = (digitsReg[11:gi*4] == '0);
            end
        end
    endgenerate

    // Select the anode and segment pattern for the current slot
    always_comb begin
        anNext  = 3'b111;
        segNext = SEG_OFF;
        case (idxReg)
            DIG_ONES: begin
                anNext  = 3'b110;
                segNext = slotSeg[0];
            end
            DIG_TENS: begin
                if (!slotBlank[1]) begin
                    anNext  = 3'b101;
                    segNext = slotSeg[1];
                end
            end
            DIG_HUND: begin
                if (!slotBlank[2]) begin
                    anNext  = 3'b011;
                    segNext = slotSeg[2];
                end
            end
            default: begin
                anNext  = 3'b111;
                segNext = SEG_OFF;
            end
        endcase
    end

    // Output registers for glitch-free pin drive
    always_ff @(posedge clk) begin
        if (rst) begin
            anReg  <= 3'b111;
            segReg <= SEG_OFF;
        end else begin
            anReg  <= anNext;
            segReg <= segNext;
        end
    end

    assign an   = anReg;
    assign seg  = segReg;
    assign dp   = 1'b1;
    assign busy = convBusy;

endmodule

// File: tb/tb_calc_seg_display.sv
// Directed bench for calc_seg_display with a fast scan rate (SCAN_DIV=4).
module tb_calc_seg_display;

    localparam int DATA_W   = 8;
    localparam int SCAN_DIV = 4;

    localparam logic [6:0] S0  = 7'b1000000;
    localparam logic [6:0] S1  = 7'b1111001;
    localparam logic [6:0] S2  = 7'b0100100;
    localparam logic [6:0] S4  = 7'b0011001;
    localparam logic [6:0] S5  = 7'b0010010;
    localparam logic [6:0] S7  = 7'b1111000;
    localparam logic [6:0] S8  = 7'b0000000;
    localparam logic [6:0] OFF = 7'h7F;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] din;
    logic              busy;
    logic [2:0]        an;
    logic [6:0]        seg;
    logic              dp;

    int vecCount  = 0;
    int missCount = 0;

    int         capCnt [3];
    logic [6:0] capSeg [3];
    int         capOff;
    int         capBad;
    int         capSegBad;

    always #5 clk = ~clk;

    calc_seg_display #(
        .DATA_W   (DATA_W),
        .SCAN_DIV (SCAN_DIV),
        .BLANK_LZ (1)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .din  (din),
        .busy (busy),
        .an   (an),
        .seg  (seg),
        .dp   (dp)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until busy equals level; cycles = edges taken, -1 on timeout
    task automatic waitBusy(input logic level, output int cycles);
        cycles = -1;
        for (int i = 1; i <= 40 && cycles < 0; i++) begin
            tick();
            if (busy === level) cycles = i;
        end
    endtask

    // Observe 12 cycles (one full scan) and record what each slot showed
    task automatic capture12();
        for (int s = 0; s < 3; s++) begin
            capCnt[s] = 0;
            capSeg[s] = 'x;
        end
        capOff = 0; capBad = 0; capSegBad = 0;
        for (int i = 0; i < 12; i++) begin
            int s;
            tick();
            s = -1;
            case (an)
                3'b110:  s = 0;
                3'b101:  s = 1;
                3'b011:  s = 2;
                3'b111:  capOff++;
                default: capBad++;
            endcase
            if (s >= 0) begin
                if (capCnt[s] == 0) capSeg[s] = seg;
                else if (seg !== capSeg[s]) capSegBad++;
                capCnt[s]++;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        din = '0;
        tick();
        tick();
        vecCount++; if (an !== 3'b111) begin missCount++; $display("FAIL reset_an: got %b want 111", an); end
        vecCount++; if (seg !== OFF) begin missCount++; $display("FAIL reset_seg: got %b want %b", seg, OFF); end
        vecCount++; if (busy !== 1'b0) begin missCount++; $display("FAIL reset_busy: got %b want 0", busy); end
        vecCount++; if (dp !== 1'b1) begin missCount++; $display("FAIL reset_dp: got %b want 1", dp); end
        rst = 1'b0;
        tick();
        vecCount++; if (an !== 3'b110 || seg !== S0) begin missCount++; $display("FAIL release_first: got an=%b seg=%b want an=110 seg=%b", an, seg, S0); end
        for (int i = 0; i < 12; i++) begin
            tick();
            vecCount++;
            if (!((an === 3'b110 && seg === S0) || an === 3'b111) || busy !== 1'b0) begin
                missCount++;
                $display("FAIL release_zero: cycle %0d got an=%b seg=%b busy=%b want an=110/111 seg=%b busy=0", i, an, seg, busy, S0);
            end
        end
        $display("test_reset: an=%b seg=%b busy=%b", an, seg, busy);
    endtask

    task automatic test_convert_255();
        int c;
        din = 8'd255;
        waitBusy(1'b1, c);
        vecCount++; if (c != 1) begin missCount++; $display("FAIL c255_busy_rise: got %0d cycles want 1", c); end
        waitBusy(1'b0, c);
        vecCount++; if (c != 9) begin missCount++; $display("FAIL c255_busy_len: got %0d cycles want 9", c); end
        capture12();
        vecCount++; if (capBad != 0 || capSegBad != 0 || capOff != 0) begin missCount++; $display("FAIL c255_scan: bad_an=%0d unstable=%0d blank=%0d want 0 0 0", capBad, capSegBad, capOff); end
        vecCount++; if (capSeg[0] !== S5) begin missCount++; $display("FAIL c255_ones: got %b want %b", capSeg[0], S5); end
        vecCount++; if (capSeg[1] !== S5) begin missCount++; $display("FAIL c255_tens: got %b want %b", capSeg[1], S5); end
        vecCount++; if (capSeg[2] !== S2) begin missCount++; $display("FAIL c255_hund: got %b want %b", capSeg[2], S2); end
        vecCount++; if (busy !== 1'b0) begin missCount++; $display("FAIL c255_idle: busy got %b want 0", busy); end
        $display("test_convert_255: ones=%b tens=%b hund=%b", capSeg[0], capSeg[1], capSeg[2]);
    endtask

    task automatic test_convert_7();
        int c;
        din = 8'd7;
        waitBusy(1'b1, c);
        vecCount++; if (c != 1) begin missCount++; $display("FAIL c7_busy_rise: got %0d cycles want 1", c); end
        waitBusy(1'b0, c);
        vecCount++; if (c != 9) begin missCount++; $display("FAIL c7_busy_len: got %0d cycles want 9", c); end
        capture12();
        vecCount++; if (capCnt[1] != 0 || capCnt[2] != 0) begin missCount++; $display("FAIL c7_blank: tens=%0d hund=%0d lit cycles want 0 0", capCnt[1], capCnt[2]); end
        vecCount++; if (capOff != 8 || capCnt[0] != 4 || capBad != 0) begin missCount++; $display("FAIL c7_slots: off=%0d ones=%0d bad=%0d want 8 4 0", capOff, capCnt[0], capBad); end
        vecCount++; if (capSeg[0] !== S7) begin missCount++; $display("FAIL c7_ones: got %b want %b", capSeg[0], S7); end
        $display("test_convert_7: ones=%b off_cycles=%0d", capSeg[0], capOff);
    endtask

    task automatic test_back_to_back();
        int c;
        int n;
        logic [6:0] want;
        din = 8'd100;
        waitBusy(1'b1, c);
        vecCount++; if (c != 1) begin missCount++; $display("FAIL b2b_busy_rise: got %0d cycles want 1", c); end
        tick(); tick(); tick();
        din = 8'd42;
        waitBusy(1'b0, c);
        vecCount++; if (c != 6) begin missCount++; $display("FAIL b2b_first_len: got %0d cycles want 6", c); end
        tick();
        vecCount++; if (busy !== 1'b1) begin missCount++; $display("FAIL b2b_restart: busy got %b want 1", busy); end
        n = 0;
        while (busy === 1'b1 && n < 20) begin
            case (an)
                3'b110:  want = S0;
                3'b101:  want = S0;
                3'b011:  want = S1;
                default: want = 'x;
            endcase
            vecCount++;
            if (want === 7'bx || seg !== want) begin
                missCount++;
                $display("FAIL b2b_show100: got an=%b seg=%b want digit of 100", an, seg);
            end
            n++;
            tick();
        end
        vecCount++; if (n != 9) begin missCount++; $display("FAIL b2b_second_len: got %0d cycles want 9", n); end
        capture12();
        vecCount++; if (capSeg[0] !== S2 || capSeg[1] !== S4) begin missCount++; $display("FAIL b2b_show42: got ones=%b tens=%b want %b %b", capSeg[0], capSeg[1], S2, S4); end
        vecCount++; if (capCnt[2] != 0 || capOff != 4 || capBad != 0) begin missCount++; $display("FAIL b2b_blank42: hund=%0d off=%0d bad=%0d want 0 4 0", capCnt[2], capOff, capBad); end
        $display("test_back_to_back: ones=%b tens=%b", capSeg[0], capSeg[1]);
    endtask

    task automatic test_mid_reset();
        int c;
        int n;
        din = 8'd200;
        waitBusy(1'b1, c);
        vecCount++; if (c != 1) begin missCount++; $display("FAIL mr_busy_rise: got %0d cycles want 1", c); end
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        vecCount++; if (an !== 3'b111 || seg !== OFF || busy !== 1'b0) begin missCount++; $display("FAIL mr_reset: got an=%b seg=%b busy=%b want 111 %b 0", an, seg, busy, OFF); end
        rst = 1'b0;
        waitBusy(1'b1, c);
        vecCount++; if (c != 1) begin missCount++; $display("FAIL mr_restart: got %0d cycles want 1", c); end
        n = 0;
        while (busy === 1'b1 && n < 20) begin
            vecCount++;
            if (!((an === 3'b110 && seg === S0) || an === 3'b111)) begin
                missCount++;
                $display("FAIL mr_zero: got an=%b seg=%b want an=110 seg=%b or an=111", an, seg, S0);
            end
            n++;
            tick();
        end
        vecCount++; if (n != 9) begin missCount++; $display("FAIL mr_reconv_len: got %0d cycles want 9", n); end
        capture12();
        vecCount++; if (capSeg[0] !== S0 || capSeg[1] !== S0 || capSeg[2] !== S2) begin missCount++; $display("FAIL mr_show200: got %b %b %b want %b %b %b", capSeg[0], capSeg[1], capSeg[2], S0, S0, S2); end
        vecCount++; if (capOff != 0 || capBad != 0) begin missCount++; $display("FAIL mr_slots200: off=%0d bad=%0d want 0 0", capOff, capBad); end
        $display("test_mid_reset: hund=%b tens=%b ones=%b", capSeg[2], capSeg[1], capSeg[0]);
    endtask

    task automatic test_scan_wrap();
        int c;
        int runLen;
        int trans;
        bit firstRun;
        logic [2:0] seqAn [24];
        logic [2:0] wantAn;
        din = 8'd128;
        waitBusy(1'b1, c);
        waitBusy(1'b0, c);
        vecCount++; if (c != 9) begin missCount++; $display("FAIL sw_busy_len: got %0d cycles want 9", c); end
        for (int j = 0; j < 24; j++) begin
            tick();
            seqAn[j] = an;
        end
        for (int j = 0; j < 24; j++) begin
            vecCount++;
            if (seqAn[j] !== 3'b110 && seqAn[j] !== 3'b101 && seqAn[j] !== 3'b011) begin
                missCount++;
                $display("FAIL sw_onehot: cycle %0d got an=%b want one low anode", j, seqAn[j]);
            end
        end
        runLen = 1; trans = 0; firstRun = 1'b1;
        for (int j = 1; j < 24; j++) begin
            if (seqAn[j] !== seqAn[j-1]) begin
                wantAn = {seqAn[j-1][1:0], seqAn[j-1][2]};
                vecCount++;
                if (seqAn[j] !== wantAn) begin missCount++; $display("FAIL sw_order: cycle %0d got an=%b want %b", j, seqAn[j], wantAn); end
                if (!firstRun) begin
                    vecCount++;
                    if (runLen != 4) begin missCount++; $display("FAIL sw_hold: cycle %0d held %0d cycles want 4", j, runLen); end
                end
                firstRun = 1'b0;
                runLen = 1;
                trans++;
            end else begin
                runLen++;
            end
        end
        vecCount++; if (trans < 5) begin missCount++; $display("FAIL sw_transitions: got %0d want at least 5", trans); end
        capture12();
        vecCount++; if (capSeg[0] !== S8 || capSeg[1] !== S2 || capSeg[2] !== S1) begin missCount++; $display("FAIL sw_show128: got %b %b %b want %b %b %b", capSeg[0], capSeg[1], capSeg[2], S8, S2, S1); end
        $display("test_scan_wrap: transitions=%0d", trans);
    endtask

    initial begin
        rst = 1'b1;
        din = '0;
        test_reset();
        test_convert_255();
        test_convert_7();
        test_back_to_back();
        test_mid_reset();
        test_scan_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
